alu_share_arbiter: RTL and testbench

Shares the single 32-bit combinational ALU between two requesters, e.g. the main datapath and a test or debug port. It takes operation requests over valid/ready handshakes and grants them round-robin. It sequences each granted operation through the ALU in a dedicated execute cycle, then holds the registered result, zero flag and gtz flag on the winner's response port until that response is accepted. Invalid opcodes never reach the ALU.

---
 rtl/alu_share_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 32-bit combinational ALU between two requesters; invalid ops bypass the ALU.
// Latency: request accepted at edge T, ALU sampled in the EXEC cycle, response held from edge T+1.
// Backpressure: no new request is accepted until the held response is consumed by its owner.
module alu_share_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_gtz,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_gtz,
  output logic        rsp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_gtz
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  // Idle ALU drive; also the safe code substituted for invalid ops.
  localparam logic [2:0] OP_ADD = 3'b010;
  // Highest defined opcode (shift-left); anything above is rejected.
  localparam logic [2:0] OP_MAX = 3'b101;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [2:0]       iss_op_q, iss_op_d;
  logic [31:0]      iss_a_q, iss_a_d;
  logic [31:0]      iss_b_q, iss_b_d;
  logic             iss_id_q, iss_id_d;
  logic [1:0]       rsp_vld_q, rsp_vld_d;
  logic [1:0][31:0] rsp_res_q, rsp_res_d;
  logic [1:0]       rsp_zero_q, rsp_zero_d;
  logic [1:0]       rsp_gtz_q, rsp_gtz_d;
  logic [1:0]       rsp_err_q, rsp_err_d;

  logic grant_vld;
  logic grant_id;
  logic iss_op_ok;
  logic rsp_hs;

  // Arbitration choice and response-handshake decode
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? prio_q : req1_valid;
    iss_op_ok = (iss_op_q <= OP_MAX);
    rsp_hs    = (state_q == RESP) && (iss_id_q ? rsp1_ready : rsp0_ready);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one op in flight, sequenced IDLE -> EXEC -> RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue/response/priority next values
  always_comb begin
    prio_d     = prio_q;
    iss_op_d   = iss_op_q;
    iss_a_d    = iss_a_q;
    iss_b_d    = iss_b_q;
    iss_id_d   = iss_id_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_res_d  = rsp_res_q;
    rsp_zero_d = rsp_zero_q;
    rsp_gtz_d  = rsp_gtz_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          iss_id_d = grant_id;
          iss_op_d = grant_id ? req1_op : req0_op;
          iss_a_d  = grant_id ? req1_a  : req0_a;
          iss_b_d  = grant_id ? req1_b  : req0_b;
        end
      end
      EXEC: begin
        rsp_vld_d[iss_id_d] = 1'b1;
        if (iss_op_ok) begin
          rsp_res_d[iss_id_q]  = alu_result;
          rsp_zero_d[iss_id_q] = alu_zero;
          rsp_gtz_d[iss_id_q]  = alu_gtz;
          rsp_err_d[iss_id_q]  = 1'b0;
        end else begin
          rsp_res_d[iss_id_q]  = 32'd0;
          rsp_zero_d[iss_id_q] = 1'b0;
          rsp_gtz_d[iss_id_q]  = 1'b0;
          rsp_err_d[iss_id_q]  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_vld_d[iss_id_q] = 1'b0;
          prio_d              = ~iss_id_q;
        end
      end
      default: ;
    endcase
  end

  // Issue/response/priority registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q     <= RR_INIT;
      iss_op_q   <= OP_ADD;
      iss_a_q    <= 32'd0;
      iss_b_q    <= 32'd0;
      iss_id_q   <= 1'b0;
      rsp_vld_q  <= 2'b00;
      rsp_res_q  <= '0;
      rsp_zero_q <= 2'b00;
      rsp_gtz_q  <= 2'b00;
      rsp_err_q  <= 2'b00;
    end else begin
      prio_q     <= prio_d;
      iss_op_q   <= iss_op_d;
      iss_a_q    <= iss_a_d;
      iss_b_q    <= iss_b_d;
      iss_id_q   <= iss_id_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_res_q  <= rsp_res_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_gtz_q  <= rsp_gtz_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Outputs: readys only in IDLE out of reset, ALU parked on add 0+0 unless executing a legal op
  always_comb begin
    req0_ready  = reset && (state_q == IDLE) && grant_vld && !grant_id;
    req1_ready  = reset && (state_q == IDLE) && grant_vld &&  grant_id;
    alu_ctrl    = OP_ADD;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    if ((state_q == EXEC) && iss_op_ok) begin
      alu_ctrl = iss_op_q;
      alu_a    = iss_a_q;
      alu_b    = iss_b_q;
    end
    rsp0_valid  = rsp_vld_q[0];
    rsp0_result = rsp_res_q[0];
    rsp0_zero   = rsp_zero_q[0];
    rsp0_gtz    = rsp_gtz_q[0];
    rsp0_err    = rsp_err_q[0];
    rsp1_valid  = rsp_vld_q[1];
    rsp1_result = rsp_res_q[1];
    rsp1_zero   = rsp_zero_q[1];
    rsp1_gtz    = rsp_gtz_q[1];
    rsp1_err    = rsp_err_q[1];
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random two-requester traffic.
// A behavioural model predicts grants, ALU drive and responses; a monitor pops and compares responses.
// Responses are backpressured randomly in the random phase.
module tb_alu_share_arbiter;
  localparam bit RR_INIT = 1'b0;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        gtz;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp0_gtz, rsp0_err, rsp1_zero, rsp1_gtz, rsp1_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, alu_gtz;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk(clk), .reset(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_gtz(rsp0_gtz), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_gtz(rsp1_gtz), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_gtz(alu_gtz)
  );

  // Environment ALU; undefined codes give a poison value so misuse shows up in results
  always_comb begin
    case (alu_ctrl)
      3'd0:    alu_result = alu_a & alu_b;
      3'd1:    alu_result = alu_a | alu_b;
      3'd2:    alu_result = alu_a + alu_b;
      3'd3:    alu_result = alu_a - alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = alu_b << alu_a;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
    alu_gtz  = (alu_a != 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected response from the operation definitions
  function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    logic [31:0] r;
    r = 32'd0;
    x.err = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a + b;
      3'd3: r = a - b;
      3'd4: r = a ^ b;
      3'd5: r = (a >= 32'd32) ? 32'd0 : (b << a[4:0]);
      default: x.err = 1'b1;
    endcase
    x.res  = r;
    x.zero = !x.err && (r == 32'd0);
    x.gtz  = !x.err && (a != 32'd0);
    return x;
  endfunction

  // Reference model: one op in flight, round-robin grant, fixed 1-cycle execute then held response
  int          m_phase = 0;  // 0 free, 1 executing, 2 response held
  logic        m_prio = RR_INIT;
  logic        m_id = 1'b0;
  logic [2:0]  m_op = 3'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;

  always @(negedge clk) begin
    logic [1:0]  er, ev;
    logic [2:0]  ec;
    logic [31:0] ea, eb;
    logic        gv, g;
    if (!rst_n) begin
      m_phase = 0;
      m_prio  = RR_INIT;
      q0.delete();
      q1.delete();
    end else begin
      er = 2'b00; ev = 2'b00; ec = 3'b010; ea = 32'd0; eb = 32'd0;
      gv = (m_phase == 0) && (req0_valid || req1_valid);
      g  = (req0_valid && req1_valid) ? m_prio : req1_valid;
      if (gv) er[g] = 1'b1;
      if (m_phase == 1 && m_op <= 3'd5) begin ec = m_op; ea = m_a; eb = m_b; end
      if (m_phase == 2) ev[m_id] = 1'b1;
      chk("req_ready", 32'({req1_ready, req0_ready}), 32'(er));
      chk("rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(ev));
      chk("alu_ctrl", 32'(alu_ctrl), 32'(ec));
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      case (m_phase)
        0: if (gv) begin
          m_id = g;
          m_op = g ? req1_op : req0_op;
          m_a  = g ? req1_a : req0_a;
          m_b  = g ? req1_b : req0_b;
          if (g) q1.push_back(ref_op(m_op, m_a, m_b));
          else   q0.push_back(ref_op(m_op, m_a, m_b));
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (m_id ? rsp1_ready : rsp0_ready) begin
          m_prio  = ~m_id;
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic mon(input bit n, input logic v, input logic r, input logic [31:0] res,
                     input logic z, input logic gz, input logic e);
    exp_t x;
    if (v) begin
      if ((n ? q1.size() : q0.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp%0d_unexpected: got a response expected none at %0t", n, $time);
      end else begin
        x = n ? q1[0] : q0[0];
        chk(n ? "rsp1_result" : "rsp0_result", res, x.res);
        chk(n ? "rsp1_zero" : "rsp0_zero", 32'(z), 32'(x.zero));
        chk(n ? "rsp1_gtz" : "rsp0_gtz", 32'(gz), 32'(x.gtz));
        chk(n ? "rsp1_err" : "rsp0_err", 32'(e), 32'(x.err));
        if (r) begin
          if (n) void'(q1.pop_front());
          else   void'(q0.pop_front());
        end
      end
    end
  endtask

  // Monitor: compare held responses against the scoreboard, pop on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      mon(1'b0, rsp0_valid, rsp0_ready, rsp0_result, rsp0_zero, rsp0_gtz, rsp0_err);
      mon(1'b1, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_gtz, rsp1_err);
    end
  end

  task automatic send(input bit n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  // Wait (bounded) for requester n to be accepted, then drop its valid just after the edge
  task automatic wait_hs(input bit n);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = n ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    chk(n ? "req1_accept_timeout" : "req0_accept_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (n) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic rand_req(input bit n);
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = 32'($urandom_range(0, 40));
      1:       a = 32'd0;
      default: a = $urandom;
    endcase
    send(n, 3'($urandom_range(0, 7)), a, ($urandom_range(0, 4) == 0) ? a : $urandom);
  endtask

  initial begin
    bit h0, h1;
    // Reset values, with a request pending to show readys are held low
    req0_valid = 1'b1;
    #2;
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    chk("rst_rsp1_flags", 32'({rsp1_zero, rsp1_gtz, rsp1_err, rsp0_zero, rsp0_gtz, rsp0_err}), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd2);
    chk("rst_alu_ab", alu_a | alu_b, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention: req0 first after reset, then req1, then req0 again
    send(1'b0, 3'd3, 32'd9, 32'd9);
    send(1'b1, 3'd1, 32'h0000_00F0, 32'h0000_000F);
    wait_hs(1'b0);
    send(1'b0, 3'd0, 32'h0000_00F3, 32'h0000_0035);
    wait_hs(1'b1);
    wait_hs(1'b0);

    // Single add on req0 with req1 idle
    send(1'b0, 3'd2, 32'd5, 32'd7);
    wait_hs(1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure on rsp1 while req0 waits
    rsp1_ready = 1'b0;
    send(1'b1, 3'd4, 32'hFFFF_0000, 32'h0000_FFFF);
    wait_hs(1'b1);
    send(1'b0, 3'd2, 32'd1, 32'd2);
    repeat (6) @(posedge clk);
    #1;
    rsp1_ready = 1'b1;
    wait_hs(1'b0);

    // Invalid ops, shift and wrap-around add
    send(1'b0, 3'd7, 32'd123, 32'd456);
    wait_hs(1'b0);
    send(1'b0, 3'd6, 32'd1, 32'd1);
    wait_hs(1'b0);
    send(1'b0, 3'd5, 32'd4, 32'd1);
    wait_hs(1'b0);
    send(1'b0, 3'd5, 32'd32, 32'hFFFF_FFFF);
    wait_hs(1'b0);
    send(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd1);
    wait_hs(1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during EXEC: in-flight request dropped, priority back to RR_INIT
    send(1'b0, 3'd2, 32'd3, 32'd4);
    wait_hs(1'b0);
    #2;
    send(1'b1, 3'd1, 32'd8, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk("mid_rst_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'd2);
    chk("mid_rst_alu_ab", alu_a | alu_b, 32'd0);
    @(posedge clk); #1;
    send(1'b0, 3'd3, 32'd1, 32'd5);
    rst_n = 1'b1;
    wait_hs(1'b0);
    wait_hs(1'b1);

    // Random traffic with random response backpressure
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (h0 || !req0_valid) begin
        if ($urandom_range(0, 2) != 0) rand_req(1'b0);
        else req0_valid = 1'b0;
      end
      if (h1 || !req1_valid) begin
        if ($urandom_range(0, 2) != 0) rand_req(1'b1);
        else req1_valid = 1'b0;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain
    @(negedge clk);
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    @(posedge clk); #1;
    if (h0) req0_valid = 1'b0;
    if (h1) req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (req0_valid) wait_hs(1'b0);
    if (req1_valid) wait_hs(1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("drain_q0_empty", 32'(q0.size()), 32'd0);
    chk("drain_q1_empty", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
